// File: rtl/ssd_scan_driver_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver.
// Segment patterns are {dp,g,f,e,d,c,b,a}, active low.
package ssd_scan_driver_pkg;

  localparam logic [13:0] ValueMax = 14'd9999;

  localparam logic [7:0] SegDash  = 8'hBF;
  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegDig0  = 8'hC0;
  localparam logic [7:0] SegDig1  = 8'hF9;
  localparam logic [7:0] SegDig2  = 8'hA4;
  localparam logic [7:0] SegDig3  = 8'hB0;
  localparam logic [7:0] SegDig4  = 8'h99;
  localparam logic [7:0] SegDig5  = 8'h92;
  localparam logic [7:0] SegDig6  = 8'h82;
  localparam logic [7:0] SegDig7  = 8'hF8;
  localparam logic [7:0] SegDig8  = 8'h80;
  localparam logic [7:0] SegDig9  = 8'h90;

  typedef enum logic [1:0] {StIdle, StRange, StShift, StLoad} conv_state_e;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SegDig0;
      4'd1:    s = SegDig1;
      4'd2:    s = SegDig2;
      4'd3:    s = SegDig3;
      4'd4:    s = SegDig4;
      4'd5:    s = SegDig5;
      4'd6:    s = SegDig6;
      4'd7:    s = SegDig7;
      4'd8:    s = SegDig8;
      4'd9:    s = SegDig9;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to four BCD nibbles.
// Out-of-range inputs skip the shift phase and report err.
module bin2bcd_seq
  import ssd_scan_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        err
);

  conv_state_e state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] adj;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bin_d   = bin;
          state_d = StRange;
        end
      end
      StRange: begin
        if (bin_q > ValueMax) begin
          err_d   = 1'b1;
          state_d = StLoad;
        end else begin
          err_d   = 1'b0;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = StLoad;
      end
      StLoad: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StLoad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign err  = err_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver: scan tick detection, digit index,
// frame-latched BCD conversion and registered active-low anode/segment outputs.
module ssd_scan_driver
  import ssd_scan_driver_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_src,
  input  logic [13:0] value,
  input  logic [3:0]  dp_en,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        busy
);

  logic        src_q;
  logic        tick, boundary;
  logic [1:0]  idx_q, idx_d;
  logic        act_q, act_d;
  logic [15:0] disp_q, disp_d;
  logic        disp_err_q, disp_err_d;
  logic [3:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        conv_busy, conv_done, conv_err;
  logic [15:0] conv_bcd;
  logic [3:0]  zero_above;
  logic [3:0]  nib;
  logic [7:0]  pat;

  assign tick     = scan_src & ~src_q;
  assign boundary = tick & (idx_q == 2'd3);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (boundary & ~conv_busy),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .err   (conv_err)
  );

  // zero_above[i]: every nibble at position i and higher is zero
  assign zero_above[3] = (disp_q[15:12] == 4'd0);
  assign zero_above[2] = zero_above[3] & (disp_q[11:8] == 4'd0);
  assign zero_above[1] = zero_above[2] & (disp_q[7:4] == 4'd0);
  assign zero_above[0] = zero_above[1] & (disp_q[3:0] == 4'd0);

  always_comb begin
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    act_d      = act_q | tick;
    disp_d     = conv_done ? conv_bcd : disp_q;
    disp_err_d = conv_done ? conv_err : disp_err_q;
    nib        = disp_q[{idx_q, 2'b00} +: 4];
    if (disp_err_q) begin
      pat = SegDash;
    end else if (BLANK_LZ && (idx_q != 2'd0) && zero_above[idx_q]) begin
      pat = SegBlank;
    end else begin
      pat = seg_digit(nib);
    end
    if (dp_en[idx_q]) pat[7] = 1'b0;
    if (act_q) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = pat;
    end else begin
      an_d  = 4'hF;
      seg_d = SegBlank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= 1'b0;
      idx_q      <= 2'd0;
      act_q      <= 1'b0;
      disp_q     <= '0;
      disp_err_q <= 1'b0;
      an_q       <= 4'hF;
      seg_q      <= SegBlank;
    end else begin
      src_q      <= scan_src;
      idx_q      <= idx_d;
      act_q      <= act_d;
      disp_q     <= disp_d;
      disp_err_q <= disp_err_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = conv_busy;

endmodule
